dff_ram_ctrl: RTL

Parametrised successor to the team's 16-byte DFF RAM for the bus-based teaching CPU.
- Generalises data width and depth.
- Replaces the single-cycle reset clear of the whole array with a sequential clear engine; the array itself has no reset.
- Adds an auto-incrementing program-load port so a loader can stream a program image without driving MAR.
- Sits between the CPU bus (MAR, data bus, ce_n/lr_n control word) and the Tiny Tapeout IO wrapper.

---
 rtl/dff_ram_pkg.sv | 13 +
 rtl/dff_ram_ctrl_if.sv | 28 ++
 rtl/dff_ram_array.sv | 23 ++
 rtl/dff_ram_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/dff_ram_pkg.sv
// Shared types and default geometry for the DFF RAM controller slice.
package dff_ram_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_PROG  = 2'd2
   } state_t;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 4;

endpackage

// File: rtl/dff_ram_ctrl_if.sv
// CPU bus and program-load port of the DFF RAM; master = CPU/loader side, slave = RAM.
interface dff_ram_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] mar;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              ce_n;
   logic              lr_n;
   logic              rd_valid;
   logic              clr_req;
   logic              prog_en;
   logic              prog_valid;
   logic [DATA_W-1:0] prog_data;
   logic [ADDR_W-1:0] prog_ptr;
   logic              busy;

   modport master (
      output mar, data_in, ce_n, lr_n, clr_req, prog_en, prog_valid, prog_data,
      input  data_out, rd_valid, prog_ptr, busy
   );

   modport slave (
      input  mar, data_in, ce_n, lr_n, clr_req, prog_en, prog_valid, prog_data,
      output data_out, rd_valid, prog_ptr, busy
   );
endinterface

// File: rtl/dff_ram_array.sv
// Flop-based storage: one synchronous write port, one combinational read port, no reset.
module dff_ram_array #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/dff_ram_ctrl.sv
// DFF RAM controller: sequential clear engine, auto-incrementing program loader and CPU read/write access.
module dff_ram_ctrl
   import dff_ram_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input logic           clk,
   input logic           rst_n,
   input logic           ena,
   dff_ram_ctrl_if.slave bus
);
   localparam int                DEPTH    = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   state_t            state;
   logic [ADDR_W-1:0] clr_ptr;
   logic [ADDR_W-1:0] prog_ptr_q;
   logic [DATA_W-1:0] data_out_q;
   logic              rd_valid_q;
   logic              busy_q;

   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;

   logic              idle_wr;
   logic              idle_rd;
   logic              prog_wr;

   // clr_req outranks prog_en, which outranks any CPU strobe; a write beats a read.
   assign idle_wr = (state == ST_IDLE) && !bus.clr_req && !bus.prog_en && !bus.lr_n;
   assign idle_rd = (state == ST_IDLE) && !bus.clr_req && !bus.prog_en && bus.lr_n && !bus.ce_n;
   assign prog_wr = (state == ST_PROG) && !bus.clr_req && bus.prog_en && bus.prog_valid;

   always_comb begin
      we    = 1'b0;
      waddr = bus.mar;
      wdata = bus.data_in;
      if (ena) begin
         if (state == ST_CLEAR) begin
            we    = 1'b1;
            waddr = clr_ptr;
            wdata = '0;
         end else if (prog_wr) begin
            we    = 1'b1;
            waddr = prog_ptr_q;
            wdata = bus.prog_data;
         end else if (idle_wr) begin
            we    = 1'b1;
         end
      end
   end

   dff_ram_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (bus.mar),
      .rdata (rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_CLEAR;
         clr_ptr    <= '0;
         prog_ptr_q <= '0;
         data_out_q <= '0;
         rd_valid_q <= 1'b0;
         busy_q     <= 1'b1;
      end else if (!ena) begin
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= idle_rd;
         if (idle_rd) data_out_q <= rdata;
         case (state)
            ST_CLEAR: begin
               clr_ptr <= clr_ptr + ADDR_W'(1);
               if (clr_ptr == LAST_PTR) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end
            end
            ST_IDLE: begin
               if (bus.clr_req) begin
                  state   <= ST_CLEAR;
                  clr_ptr <= '0;
                  busy_q  <= 1'b1;
               end else if (bus.prog_en) begin
                  state      <= ST_PROG;
                  prog_ptr_q <= '0;
                  busy_q     <= 1'b1;
               end
            end
            ST_PROG: begin
               if (bus.clr_req) begin
                  state   <= ST_CLEAR;
                  clr_ptr <= '0;
                  busy_q  <= 1'b1;
               end else if (!bus.prog_en) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end else if (bus.prog_valid) begin
                  prog_ptr_q <= prog_ptr_q + ADDR_W'(1);
               end
            end
            default: begin
               state   <= ST_CLEAR;
               clr_ptr <= '0;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.data_out = data_out_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.prog_ptr = prog_ptr_q;
   assign bus.busy     = busy_q;

endmodule
